// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the multiplier-array controller, its accumulator and benches.
// The tag carries {valid, last, m, n} alongside each product through the array.
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    localparam int TAG_VALID_W = 1;
    localparam int TAG_LAST_W  = 1;
    localparam int DRAIN_CNT_W = 2;

    // Tag layout, MSB first: valid, last, m index, n index.
    function automatic int tag_width(input int cw);
        return TAG_VALID_W + TAG_LAST_W + 2 * cw;
    endfunction

endpackage

// File: rtl/mult_tag_pipe.sv
// Tag delay line matching the multiplier array latency.
// Shifts only while the array is enabled so tags stay aligned with products.
module mult_tag_pipe #(
    parameter int MUL_LAT = 1,
    parameter int TAG_W   = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic [TAG_W-1:0] push_tag,
    output logic [TAG_W-1:0] tail_tag
);

    logic [TAG_W-1:0] stage [MUL_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                stage[i] <= '0;
            end
        end else if (shift) begin
            stage[0] <= push_tag;
            for (int i = 1; i < MUL_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tail_tag = stage[MUL_LAT-1];

endmodule

// File: rtl/mult_array_ctrl.sv
// Sequencer for a tiled multiplier array: walks k/n/m tile loops, tags each
// issued operand pair, and drains the array before signalling completion.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; rejects zero-sized configs
// ST_RUN   | issuing operand pairs, one per cycle when valid and ready
// ST_DRAIN | last pair issued; flushing MUL_LAT enabled cycles
// ST_DONE  | one-cycle completion pulse, then back to idle
module mult_array_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int CW      = 8,
    parameter int MUL_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] cfg_m,
    input  logic [CW-1:0] cfg_n,
    input  logic [CW-1:0] cfg_k,
    input  logic          opnd_valid,
    output logic          opnd_ready,
    input  logic          acc_ready,
    output logic          arr_enable,
    output logic [1:0]    arr_in_valid,
    output logic          out_valid,
    output logic          out_last,
    output logic [CW-1:0] out_m,
    output logic [CW-1:0] out_n,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam int TAG_W = tag_width(CW);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(MUL_LAT - 1);

    ctrl_state_t state, state_nx;

    logic [CW-1:0] lim_m, lim_n, lim_k;
    logic [CW-1:0] cnt_m, cnt_n, cnt_k;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic cfg_err_q;

    logic cfg_ok, accept, issue;
    logic k_last, n_last, m_last, job_last;
    logic [TAG_W-1:0] push_tag, tail_tag;

    assign cfg_ok   = (cfg_m != '0) && (cfg_n != '0) && (cfg_k != '0);
    assign accept   = (state == ST_IDLE) && start && cfg_ok;
    assign issue    = (state == ST_RUN) && opnd_valid && acc_ready;
    assign k_last   = (cnt_k == lim_k - ONE);
    assign n_last   = (cnt_n == lim_n - ONE);
    assign m_last   = (cnt_m == lim_m - ONE);
    assign job_last = issue && k_last && n_last && m_last;

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nx = ST_RUN;
            ST_RUN:   if (job_last) state_nx = ST_DRAIN;
            ST_DRAIN: if (acc_ready && drain_cnt == '0) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            lim_m     <= '0;
            lim_n     <= '0;
            lim_k     <= '0;
            cnt_m     <= '0;
            cnt_n     <= '0;
            cnt_k     <= '0;
            drain_cnt <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cfg_err_q <= (state == ST_IDLE) && start && !cfg_ok;

            if (accept) begin
                lim_m <= cfg_m;
                lim_n <= cfg_n;
                lim_k <= cfg_k;
                cnt_m <= '0;
                cnt_n <= '0;
                cnt_k <= '0;
            end else if (issue) begin
                // k innermost, carrying into n, then m
                if (k_last) begin
                    cnt_k <= '0;
                    if (n_last) begin
                        cnt_n <= '0;
                        cnt_m <= m_last ? '0 : cnt_m + ONE;
                    end else begin
                        cnt_n <= cnt_n + ONE;
                    end
                end else begin
                    cnt_k <= cnt_k + ONE;
                end
            end

            if (job_last) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state == ST_DRAIN && acc_ready && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
        end
    end

    assign opnd_ready   = issue;
    assign arr_in_valid = {issue && k_last, issue};
    assign arr_enable   = acc_ready && (state == ST_RUN || state == ST_DRAIN);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign cfg_err      = cfg_err_q;

    assign push_tag = {issue, issue && k_last, cnt_m, cnt_n};

    mult_tag_pipe #(
        .MUL_LAT (MUL_LAT),
        .TAG_W   (TAG_W)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .shift    (arr_enable),
        .push_tag (push_tag),
        .tail_tag (tail_tag)
    );

    assign out_valid = tail_tag[TAG_W-1];
    assign out_last  = tail_tag[TAG_W-2];
    assign out_m     = tail_tag[2*CW-1:CW];
    assign out_n     = tail_tag[CW-1:0];

endmodule

// File: tb/tb_mult_array_ctrl.sv
// Directed bench for mult_array_ctrl: a per-cycle vector table plus job-level
// sequences checked against a k/n/m loop model, with MUL_LAT=1 and MUL_LAT=3 instances.
module tb_mult_array_ctrl;

    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset, start, opnd_valid, acc_ready;
    logic [CW-1:0] cfg_m, cfg_n, cfg_k;

    logic a_ordy, a_en, a_oval, a_olast, a_busy, a_done, a_err;
    logic [1:0] a_inv;
    logic [CW-1:0] a_om, a_on;
    logic b_ordy, b_en, b_oval, b_olast, b_busy, b_done, b_err;
    logic [1:0] b_inv;
    logic [CW-1:0] b_om, b_on;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_array_ctrl #(.CW(CW), .MUL_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
        .opnd_valid(opnd_valid), .opnd_ready(a_ordy), .acc_ready(acc_ready),
        .arr_enable(a_en), .arr_in_valid(a_inv), .out_valid(a_oval), .out_last(a_olast),
        .out_m(a_om), .out_n(a_on), .busy(a_busy), .done(a_done), .cfg_err(a_err)
    );

    mult_array_ctrl #(.CW(CW), .MUL_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
        .opnd_valid(opnd_valid), .opnd_ready(b_ordy), .acc_ready(acc_ready),
        .arr_enable(b_en), .arr_in_valid(b_inv), .out_valid(b_oval), .out_last(b_olast),
        .out_m(b_om), .out_n(b_on), .busy(b_busy), .done(b_done), .cfg_err(b_err)
    );

    logic [24:0] a_all, b_all;
    assign a_all = {a_ordy, a_en, a_inv, a_oval, a_olast, a_om, a_on, a_busy, a_done, a_err};
    assign b_all = {b_ordy, b_en, b_inv, b_oval, b_olast, b_om, b_on, b_busy, b_done, b_err};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor on the MUL_LAT=1 instance: issues, last flags, consumed products.
    int n_issue, n_last;
    logic [63:0] last_mask;
    logic [2*CW:0] obs [$];

    always @(negedge clk) begin
        if (!reset) begin
            if (a_ordy) begin
                n_issue++;
                if (a_inv[1]) begin
                    n_last++;
                    if (n_issue < 64) last_mask[n_issue] = 1'b1;
                end
            end
            if (a_oval && a_en) obs.push_back({a_olast, a_om, a_on});
        end
    end

    task automatic clear_mon();
        n_issue = 0;
        n_last = 0;
        last_mask = '0;
        obs.delete();
    endtask

    // Holds reset (with a valid start present, which must be ignored) and checks
    // all outputs are zero on the cycle after. Ends at posedge+1 of an idle cycle.
    task automatic do_reset();
        reset = 1'b1; start = 1'b1;
        cfg_m = 8'd1; cfg_n = 8'd1; cfg_k = 8'd1;
        opnd_valid = 1'b1; acc_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset_outputs_lat1", a_all, '0);
        chk("reset_outputs_lat3", b_all, '0);
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 carries start; later cycles apply opnd_valid/acc_ready patterns.
    task automatic run_job(input int m, input int n, input int k, input bit toggle,
                           input int stall_at, input int stall_len,
                           input logic [2*CW+1:0] hold_exp,
                           output int d1, output int d3, output int v3,
                           output logic [1:0] inv3_c1);
        int nc;
        d1 = -1; d3 = -1; v3 = -1; inv3_c1 = 2'b00;
        clear_mon();
        start = 1'b1;
        cfg_m = CW'(m); cfg_n = CW'(n); cfg_k = CW'(k);
        opnd_valid = 1'b1; acc_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && (d1 < 0 || d3 < 0); cyc++) begin
            @(negedge clk);
            if (a_done && d1 < 0) d1 = cyc;
            if (b_done && d3 < 0) d3 = cyc;
            if (b_oval && v3 < 0) v3 = cyc;
            if (cyc == 1) inv3_c1 = b_inv;
            if (!acc_ready) begin
                chk("stall_enable", a_en, 1'b0);
                chk("stall_issue", a_ordy, 1'b0);
                chk("stall_hold", {a_oval, a_olast, a_om, a_on}, hold_exp);
            end
            if (toggle && cyc >= 2 && cyc <= 8)
                chk($sformatf("bubble_out_valid_c%0d", cyc), a_oval, (cyc % 2 == 0));
            @(posedge clk);
            #1;
            // Config changes while busy must not affect the running job.
            start = 1'b0;
            cfg_m = 8'd3; cfg_n = 8'd3; cfg_k = 8'd3;
            nc = cyc + 1;
            opnd_valid = toggle ? nc[0] : 1'b1;
            acc_ready = !(nc >= stall_at && nc < stall_at + stall_len);
        end
        cfg_m = '0; cfg_n = '0; cfg_k = '0;
        opnd_valid = 1'b1; acc_ready = 1'b1;
    endtask

    task automatic check_job(input string tag, input int m, input int n, input int k,
                             input int d1, input int exp_d1);
        logic [2*CW:0] e [$];
        logic [63:0] emask;
        int idx;
        emask = '0;
        idx = 0;
        for (int mi = 0; mi < m; mi++)
            for (int ni = 0; ni < n; ni++)
                for (int ki = 0; ki < k; ki++) begin
                    idx++;
                    if (ki == k - 1) emask[idx] = 1'b1;
                    e.push_back({(ki == k - 1), CW'(mi), CW'(ni)});
                end
        chk({tag, "_issues"}, n_issue, m * n * k);
        chk({tag, "_last_count"}, n_last, m * n);
        chk({tag, "_last_positions"}, last_mask, emask);
        chk({tag, "_out_count"}, obs.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            chk($sformatf("%s_out%0d", tag, i),
                (i < obs.size()) ? obs[i] : {(2*CW+1){1'bx}}, e[i]);
        chk({tag, "_done_cycle"}, d1, exp_d1);
    endtask

    typedef struct {
        logic start;
        logic [CW-1:0] m, n, k;
        logic ov, ar;
        logic [8:0] exp; // {ordy, en, in_valid[1:0], out_valid, out_last, busy, done, cfg_err}
    } vec_t;

    vec_t vec [11];

    initial begin
        int d1, d3, v3, done_seen;
        logic [1:0] inv3;

        // cfg 1,1,2 on MUL_LAT=1 with a bubble, a stall, ignored starts and a rejected start
        vec[0]  = '{1'b1, 8'd1, 8'd1, 8'd2, 1'b1, 1'b1, 9'b0_0_00_0_0_0_0_0};
        vec[1]  = '{1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 9'b1_1_01_0_0_1_0_0};
        vec[2]  = '{1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 9'b0_1_00_1_0_1_0_0};
        vec[3]  = '{1'b1, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 9'b0_0_00_0_0_1_0_0};
        vec[4]  = '{1'b0, 8'd5, 8'd5, 8'd5, 1'b1, 1'b1, 9'b1_1_11_0_0_1_0_0};
        vec[5]  = '{1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 9'b0_1_00_1_1_1_0_0};
        vec[6]  = '{1'b1, 8'd1, 8'd1, 8'd1, 1'b1, 1'b1, 9'b0_0_00_0_0_1_1_0};
        vec[7]  = '{1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 9'b0_0_00_0_0_0_0_0};
        vec[8]  = '{1'b1, 8'd1, 8'd0, 8'd1, 1'b1, 1'b1, 9'b0_0_00_0_0_0_0_0};
        vec[9]  = '{1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 9'b0_0_00_0_0_0_0_1};
        vec[10] = '{1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 9'b0_0_00_0_0_0_0_0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            start = vec[i].start;
            cfg_m = vec[i].m; cfg_n = vec[i].n; cfg_k = vec[i].k;
            opnd_valid = vec[i].ov; acc_ready = vec[i].ar;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {a_ordy, a_en, a_inv, a_oval, a_olast, a_busy, a_done, a_err}, vec[i].exp);
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        // 2x2x3 back-to-back
        do_reset();
        run_job(2, 2, 3, 1'b0, 1000, 0, '0, d1, d3, v3, inv3);
        check_job("job223", 2, 2, 3, d1, 14);

        // single tile, MUL_LAT=3 timing
        do_reset();
        run_job(1, 1, 1, 1'b0, 1000, 0, '0, d1, d3, v3, inv3);
        check_job("job111", 1, 1, 1, d1, 3);
        chk("lat3_in_valid", inv3, 2'b11);
        chk("lat3_out_valid_cycle", v3, 4);
        chk("lat3_done_cycle", d3, 5);

        // 1x2x2 with a five-cycle acc_ready stall after three issues
        do_reset();
        run_job(1, 2, 2, 1'b0, 4, 5, {1'b1, 1'b0, 8'd0, 8'd1}, d1, d3, v3, inv3);
        check_job("job122_stall", 1, 2, 2, d1, 11);

        // 1x1x4 with opnd_valid toggling
        do_reset();
        run_job(1, 1, 4, 1'b1, 1000, 0, '0, d1, d3, v3, inv3);
        check_job("job114_bubbles", 1, 1, 4, d1, 9);

        // reset during issue 5 of a 2x2x2 job
        do_reset();
        clear_mon();
        start = 1'b1;
        cfg_m = 8'd2; cfg_n = 8'd2; cfg_k = 8'd2;
        opnd_valid = 1'b1; acc_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        @(negedge clk);
        chk("pre_reset_issue5", a_ordy, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("midjob_reset_lat1", a_all, '0);
        chk("midjob_reset_lat3", b_all, '0);
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (a_done || b_done) done_seen = 1;
        end
        chk("no_done_after_reset", done_seen, 0);
        @(posedge clk);
        #1;
        run_job(1, 1, 1, 1'b0, 1000, 0, '0, d1, d3, v3, inv3);
        check_job("job111_after_reset", 1, 1, 1, d1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_array_ctrl.md
MULT_ARRAY_CTRL -- requirements
Module: mult_array_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CW, 8, width of each tile-count config field.
- MUL_LAT, 1, multiplier array latency in enabled cycles, range 1..4.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, launch job; sampled in IDLE only.
- cfg_m, in, CW, M tile count.
- cfg_n, in, CW, N tile count.
- cfg_k, in, CW, K tile count.
- opnd_valid, in, 1, operand fetch has a tile pair ready.
- opnd_ready, out, 1, operand pair consumed this cycle.
- acc_ready, in, 1, accumulator can advance/accept.
- arr_enable, out, 1, drives array enable.
- arr_in_valid, out, 2, drives array in_valid: bit0 = operand valid, bit1 = last K slice.
- out_valid, out, 1, array output product valid.
- out_last, out, 1, product is last K slice of its (m,n) tile.
- out_m, out, CW, M index of the product at output.
- out_n, out, CW, N index of the product at output.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle job-complete pulse.
- cfg_err, out, 1, one-cycle pulse on a rejected start.

Function
REQ-003 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-004 In IDLE, start=1 with cfg_m, cfg_n and cfg_k all nonzero SHALL latch the config, clear counters k, n and m, and enter RUN on the next cycle.
REQ-005 In IDLE, start=1 with any config field zero SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-006 start SHALL be ignored outside IDLE.
REQ-007 The issue condition SHALL be issue = (state==RUN) && opnd_valid && acc_ready.
REQ-008 opnd_ready SHALL equal issue.
REQ-009 arr_in_valid[0] SHALL equal issue.
REQ-010 arr_in_valid[1] SHALL equal issue && (k==cfg_k-1).
REQ-011 arr_enable SHALL equal acc_ready && (state==RUN || state==DRAIN).
REQ-012 When acc_ready=0, the array and the tag pipeline SHALL freeze.
REQ-013 When opnd_valid=0 and acc_ready=1, a bubble (in_valid[0]=0) SHALL enter the pipeline.
REQ-014 Loop order SHALL be k innermost, then n, then m; each counter wraps to 0 when it passes its last value and carries into the next counter.
REQ-015 Each issue SHALL push a tag {valid, last, m, n} into a MUL_LAT-deep shift register; the register shifts only when arr_enable=1; a non-issue enabled cycle pushes valid=0.
REQ-016 out_valid, out_last, out_m and out_n SHALL come from the tail tag, so a product issued at cycle t appears at the output after exactly MUL_LAT enabled cycles.
REQ-017 out_valid SHALL be held stable while acc_ready=0.
REQ-018 An issue with k==cfg_k-1, n==cfg_n-1 and m==cfg_m-1 SHALL move the FSM to DRAIN.
REQ-019 DRAIN SHALL count MUL_LAT enabled cycles, then go to DONE.
REQ-020 DONE SHALL assert done for one cycle and return to IDLE.
REQ-021 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-022 Total issues per job SHALL equal cfg_m*cfg_n*cfg_k, with exactly cfg_m*cfg_n issues carrying last=1.
REQ-023 A config of 1,1,1 SHALL issue once, go to DRAIN in the same cycle, and produce done MUL_LAT+1 enabled cycles after the issue.
REQ-024 Config inputs SHALL be ignored while busy=1; the latched copy is used.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, clear all counters and tags, and take effect mid-job.
REQ-026 Outputs SHALL be 0 on the cycle after reset: opnd_ready, arr_enable, arr_in_valid, out_valid, out_last, out_m, out_n, busy, done, cfg_err.
REQ-027 A job interrupted by reset SHALL NOT produce done.
REQ-028 start asserted during reset SHALL be ignored.

Structure
REQ-029 The FSM state encoding and the tag field widths SHALL live in a shared package mult_ctrl_pkg for reuse by the accumulator and testbench.
REQ-030 The tag shift register SHALL be a sub-module mult_tag_pipe (parameters MUL_LAT and tag width, with a shift enable).
REQ-031 The FSM and counters SHALL stay in mult_array_ctrl.

Verification
REQ-032 cfg 2,2,3, MUL_LAT=1, opnd_valid=acc_ready=1 -> 12 consecutive issues; last=1 on issues 3,6,9,12; out (m,n) sequence (0,0)x3,(0,1)x3,(1,0)x3,(1,1)x3; done at cycle 14 after start.
REQ-033 cfg 1,1,1, MUL_LAT=3 -> one issue with arr_in_valid=2'b11; out_valid 3 enabled cycles later; done one cycle after that.
REQ-034 cfg 1,2,2 with acc_ready low for 5 cycles mid-job -> arr_enable=0 and no issues during the stall; outputs held; total issues still 4; tag order unchanged.
REQ-035 opnd_valid toggling 1,0,1,0 -> bubbles with out_valid=0 interleaved; 4 valid outputs for cfg 1,1,4.
REQ-036 start with cfg_n=0 -> cfg_err pulse; busy stays 0; no issue.
REQ-037 reset asserted at issue 5 of cfg 2,2,2 -> all outputs 0 next cycle; no done; a following start with cfg 1,1,1 completes normally.
